lap_buffer: RTL
===============

# lap_buffer

Captures lap (split) times from the stopwatch counter into a small first-in-first-out buffer for later readout. Sits directly downstream of the stopwatch controller. It samples the 8-bit elapsed-time count and the controller's running indication, and records an entry on each lap request. Each entry holds the absolute time and the delta since the previous lap. Entries are drained by the display/readout logic through a first-word-fall-through read port.

## Interface
- DEPTH, 4, number of lap entries; power of two, ≥2
- W, 8, elapsed-time width; must match the upstream counter
- clk  in  1  single system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- elapsed_time  in  W  current stopwatch count from upstream
- running  in  1  high while the upstream controller is counting
- lap  in  1  lap request level (already synchronised); acted on at its 0→1 edge
- clear  in  1  synchronous clear of buffer, flags and delta base
- rd_en  in  1  pop the head entry (read-acknowledge)
- lap_abs  out  W  head entry: absolute time at capture
- lap_delta  out  W  head entry: time since previous capture, modulo 2^W
- lap_valid  out  1  buffer non-empty; lap_abs/lap_delta meaningful
- lap_count  out  clog2(DEPTH)+1  entries currently held
- full  out  1  lap_count == DEPTH
- overflow  out  1  sticky; a capture was dropped because the buffer was full

## Operation
- Edge detect: internal register lap_q holds the previous-cycle lap.
  - capture_req = lap & ~lap_q & running.
  - A lap edge while running=0 is discarded; it is not deferred.
- Capture, when capture_req is asserted and the buffer is not full (or a pop occurs in the same cycle):
  - Write {elapsed_time, elapsed_time − last_cap} at the tail, with W-bit wrap-around subtraction.
  - last_cap ← elapsed_time.
- Capture while full with no simultaneous pop:
  - Entry dropped; overflow ← 1.
  - last_cap unchanged.
- Read is first-word-fall-through:
  - lap_abs/lap_delta always show the head entry.
  - rd_en with lap_valid=1 pops the head.
  - rd_en while empty is ignored; no underflow state change.
- Simultaneous capture and pop:
  - Both take effect; lap_count unchanged.
  - When full, the pop frees the slot and the capture is accepted, with no overflow.
  - When empty, the pop is ignored and the capture proceeds.
- clear has highest priority. In its cycle, capture and pop are ignored and the following are zeroed:
  - head and tail pointers, lap_count, overflow
  - last_cap
  - lap_q is still updated from lap.
- Pointers are log2(DEPTH) bits and wrap naturally. lap_count is tracked separately, or via extended pointers.
- Entries are not erased on pop. When empty, lap_abs/lap_delta are don't-care; the bench must check them only when lap_valid=1.

## Timing
- Reset (rst_n low, asynchronous) forces the following; release takes effect at the next clk edge.
  - lap_count=0, lap_valid=0, full=0, overflow=0
  - lap_abs=0, lap_delta=0, last_cap=0, lap_q=0
  - pointers 0
- Capture latency: lap rises before edge N (lap_q=0, running=1 at edge N). After edge N:
  - the entry is stored and lap_count increments;
  - lap_valid and the new head are visible.
- Captured value is elapsed_time as sampled at edge N, not the next value.
- Pop latency: rd_en high at edge N; after edge N the next entry (or lap_valid=0) is presented.
- Back-to-back pops: one entry per cycle.
- Captures are limited to one per lap rising edge; a lap held high captures once.
- full and overflow update in the same cycle as lap_count.
- overflow clears only on clear or reset.

## Test plan
- Reset, then idle: lap_count=0, lap_valid=0, full=0, overflow=0, all outputs 0.
- Start running, pulse lap at elapsed_time 10, 25, 40. Read three times:
  - (10,10), (25,15), (40,15) in order;
  - lap_valid then drops and lap_count returns to 0.
- Lap at 250, then at 4 after the counter wraps: second entry lap_delta=10.
- Lap held high for 5 cycles → exactly one capture.
- Lap pulse while running=0 → no capture.
- Fill to DEPTH=4:
  - 5th lap → dropped, overflow=1, full stays 1.
  - Lap together with rd_en while full → accepted; lap_count stays 4; overflow not newly set.
- clear together with lap and rd_en while holding 2 entries → lap_count=0, overflow=0.
  - Next lap at 30 → (30,30).
  - Assert rst_n low mid-run → all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/lap_buffer.sv
// lap_buffer
//
// Records lap (split) times from the stopwatch counter into a small FIFO.
// Each entry holds the absolute time at capture and the delta since the
// previous accepted capture (modulo 2^W). The read port is
// first-word-fall-through: the head entry is always presented on
// lap_abs/lap_delta, and rd_en acknowledges and pops it.
//
// Read handshake: lap_valid is the "valid" of the head entry and rd_en is
// the consumer's "ready". An entry is transferred, and popped, on a rising
// clk edge where both are high. rd_en while lap_valid is low has no effect.
//
// Ports
//   clk           single system clock, rising edge
//   rst_n         asynchronous active-low reset
//   elapsed_time  current stopwatch count (W bits)
//   running       high while the upstream controller is counting
//   lap           lap request level; a capture happens on its 0->1 edge
//   clear         synchronous clear of entries, flags and delta base
//   rd_en         pop the head entry
//   lap_abs       head entry: absolute time at capture
//   lap_delta     head entry: time since previous capture
//   lap_valid     buffer non-empty
//   lap_count     number of entries held (0..DEPTH)
//   full          lap_count == DEPTH
//   overflow      sticky: a capture was dropped because the buffer was full

module lap_buffer #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [W-1:0]             elapsed_time,
  input  logic                     running,
  input  logic                     lap,
  input  logic                     clear,
  input  logic                     rd_en,
  output logic [W-1:0]             lap_abs,
  output logic [W-1:0]             lap_delta,
  output logic                     lap_valid,
  output logic [$clog2(DEPTH):0]   lap_count,
  output logic                     full,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic          lap_q,      lap_d;
  logic [W-1:0]  last_cap_q, last_cap_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic          overflow_q, overflow_d;

  logic [W-1:0]  abs_mem_q   [DEPTH];
  logic [W-1:0]  delta_mem_q [DEPTH];

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic          capture_req;
  logic          empty;
  logic          is_full;
  logic          pop;
  logic          accept;
  logic          drop;
  logic [W-1:0]  cap_delta;

  // A lap edge while stopped is discarded, not remembered for later.
  assign capture_req = lap & ~lap_q & running;
  assign empty       = (count_q == '0);
  assign is_full     = (count_q == DEPTH_C);

  // clear wins over both capture and pop.
  assign pop    = rd_en & ~empty & ~clear;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign accept = capture_req & ~clear & (~is_full | pop);
  assign drop   = capture_req & ~clear & is_full & ~pop;

  // Natural W-bit wrap gives the modulo-2^W delta across counter rollover.
  assign cap_delta = elapsed_time - last_cap_q;

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    lap_d      = lap;
    last_cap_d = last_cap_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (clear) begin
      last_cap_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_d   = wr_ptr_q + 1'b1;
        last_cap_d = elapsed_time;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({accept, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q      <= 1'b0;
      last_cap_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      lap_q      <= lap_d;
      last_cap_q <= last_cap_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is reset so the head outputs read 0 out of reset. Entries are
  // not erased on pop or clear; they are only meaningful while lap_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        abs_mem_q[i]   <= '0;
        delta_mem_q[i] <= '0;
      end
    end else if (accept) begin
      abs_mem_q[wr_ptr_q]   <= elapsed_time;
      delta_mem_q[wr_ptr_q] <= cap_delta;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign lap_abs   = abs_mem_q[rd_ptr_q];
  assign lap_delta = delta_mem_q[rd_ptr_q];
  assign lap_valid = ~empty;
  assign lap_count = count_q;
  assign full      = is_full;
  assign overflow  = overflow_q;

endmodule
